// File: rtl/omem_potential_store.sv
// Output-memory node: stores Sum PE membrane potentials and spike bits per timestep,
// answers previous-potential requests and exposes spikes on a registered readout port.
module omem_potential_store #(
    parameter int         NUM_SPE       = 5,
    parameter int         OUT_DIM       = 21,
    parameter int         POT_WIDTH     = 13,
    parameter int         NUM_TIMESTEPS = 2,
    parameter logic [3:0] SPE_ADDR_BASE = 4'd5,
    parameter logic [3:0] OP_PREV_POT   = 4'd2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        pkt_valid,
    output logic        pkt_ready,
    input  logic [3:0]  pkt_opcode,
    input  logic [24:0] pkt_data,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [3:0]  rsp_dest,
    output logic [3:0]  rsp_opcode,
    output logic [24:0] rsp_data,
    input  logic        spk_rd_ts,
    input  logic [8:0]  spk_rd_addr,
    output logic        spk_rd_data,
    output logic        ts_done,
    output logic        cur_ts,
    output logic        all_done,
    output logic        err
);
    localparam int NUM_NEURONS = OUT_DIM * OUT_DIM;
    localparam int ADDR_W      = 9;
    localparam int PTR_W       = 10;
    localparam int ROW_W       = 5;
    localparam int COL_W       = 5;
    localparam int CNT_W       = 9;

    logic [2:0]                          spe_id;
    logic                                req;
    logic [NUM_SPE-1:0][ROW_W-1:0]       row_all;
    logic [NUM_SPE-1:0][PTR_W-1:0]       addr_all;
    logic [ROW_W-1:0]                    sel_row;
    logic [PTR_W-1:0]                    sel_addr;
    logic                                bad_id, exhausted, accept;
    logic                                wr_ok, rd_ok, rd_fetch, proto_err, ts_end, last_ts;
    logic                                rsp_valid_next, all_done_next;

    logic                                pkt_ready_reg, rsp_valid_reg, rsp_zero_reg;
    logic [3:0]                          rsp_dest_reg, rsp_opcode_reg;
    logic                                ts_done_reg, cur_ts_reg, all_done_reg, err_reg;
    logic                                spk_rd_data_reg;
    logic [CNT_W-1:0]                    wr_cnt_reg;
    logic [NUM_TIMESTEPS-1:0][NUM_NEURONS-1:0] spike_reg;
    logic [POT_WIDTH-1:0]                pot_mem [NUM_NEURONS];
    logic [POT_WIDTH-1:0]                pot_q;
    logic                                unused_bits;

    assign spe_id = pkt_opcode[3:1];
    assign req    = pkt_opcode[0];

    always_comb begin
        sel_row  = '0;
        sel_addr = '0;
        for (int i = 0; i < NUM_SPE; i++) begin
            if (spe_id == 3'(i)) begin
                sel_row  = row_all[i];
                sel_addr = addr_all[i];
            end
        end
    end

    assign bad_id    = (spe_id >= 3'(NUM_SPE));
    assign exhausted = (sel_row >= ROW_W'(OUT_DIM));
    assign accept    = pkt_valid && pkt_ready_reg;
    assign wr_ok     = accept && !req && !bad_id && !exhausted;
    assign rd_ok     = accept && req && !bad_id;
    assign rd_fetch  = rd_ok && !exhausted;
    assign proto_err = accept && (bad_id || exhausted);
    assign ts_end    = wr_ok && (wr_cnt_reg == CNT_W'(NUM_NEURONS - 1));
    assign last_ts   = (cur_ts_reg == 1'(NUM_TIMESTEPS - 1));

    assign rsp_valid_next = rd_ok ? 1'b1 : ((rsp_valid_reg && rsp_ready) ? 1'b0 : rsp_valid_reg);
    assign all_done_next  = all_done_reg || (ts_end && last_ts);

    // Per-SPE pointer tracked as row/col plus a running flat address: wrapping a row
    // jumps forward past the NUM_SPE-1 rows owned by the other Sum PEs.
    genvar gi;
    generate
        for (gi = 0; gi < NUM_SPE; gi++) begin : g_ptr
            logic [ROW_W-1:0] row_reg;
            logic [COL_W-1:0] col_reg;
            logic [PTR_W-1:0] addr_reg;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    row_reg  <= ROW_W'(gi);
                    col_reg  <= '0;
                    addr_reg <= PTR_W'(gi * OUT_DIM);
                end else if (ts_end) begin
                    row_reg  <= ROW_W'(gi);
                    col_reg  <= '0;
                    addr_reg <= PTR_W'(gi * OUT_DIM);
                end else if (wr_ok && spe_id == 3'(gi)) begin
                    if (col_reg == COL_W'(OUT_DIM - 1)) begin
                        col_reg  <= '0;
                        row_reg  <= row_reg + ROW_W'(NUM_SPE);
                        addr_reg <= addr_reg + PTR_W'(1 + (NUM_SPE - 1) * OUT_DIM);
                    end else begin
                        col_reg  <= col_reg + 1'b1;
                        addr_reg <= addr_reg + 1'b1;
                    end
                end
            end

            assign row_all[gi]  = row_reg;
            assign addr_all[gi] = addr_reg;
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pkt_ready_reg   <= 1'b0;
            rsp_valid_reg   <= 1'b0;
            rsp_zero_reg    <= 1'b0;
            rsp_dest_reg    <= '0;
            rsp_opcode_reg  <= '0;
            ts_done_reg     <= 1'b0;
            cur_ts_reg      <= 1'b0;
            all_done_reg    <= 1'b0;
            err_reg         <= 1'b0;
            wr_cnt_reg      <= '0;
            spike_reg       <= '0;
            spk_rd_data_reg <= 1'b0;
        end else begin
            pkt_ready_reg <= !rsp_valid_next && !all_done_next;
            rsp_valid_reg <= rsp_valid_next;
            ts_done_reg   <= ts_end;
            all_done_reg  <= all_done_next;
            if (proto_err)
                err_reg <= 1'b1;
            if (ts_end) begin
                wr_cnt_reg <= '0;
                if (!last_ts)
                    cur_ts_reg <= cur_ts_reg + 1'b1;
            end else if (wr_ok) begin
                wr_cnt_reg <= wr_cnt_reg + 1'b1;
            end
            if (rd_ok) begin
                rsp_dest_reg   <= SPE_ADDR_BASE + {1'b0, spe_id};
                rsp_opcode_reg <= OP_PREV_POT;
                rsp_zero_reg   <= exhausted || (cur_ts_reg == 1'b0);
            end
            if (wr_ok)
                spike_reg[cur_ts_reg][sel_addr[ADDR_W-1:0]] <= pkt_data[0];
            spk_rd_data_reg <= (spk_rd_addr < ADDR_W'(NUM_NEURONS))
                             ? spike_reg[spk_rd_ts][spk_rd_addr] : 1'b0;
        end
    end

    // Potential storage is plain block RAM; it keeps its contents across reset.
    always_ff @(posedge clk) begin
        if (wr_ok)
            pot_mem[sel_addr[ADDR_W-1:0]] <= pkt_data[POT_WIDTH:1];
        if (rd_fetch)
            pot_q <= pot_mem[sel_addr[ADDR_W-1:0]];
    end

    assign unused_bits = ^{pkt_data[24:POT_WIDTH+1], sel_addr[PTR_W-1:ADDR_W]};

    assign pkt_ready   = pkt_ready_reg;
    assign rsp_valid   = rsp_valid_reg;
    assign rsp_dest    = rsp_dest_reg;
    assign rsp_opcode  = rsp_opcode_reg;
    assign rsp_data    = (rsp_valid_reg && !rsp_zero_reg) ? {{(25 - POT_WIDTH){1'b0}}, pot_q} : '0;
    assign spk_rd_data = spk_rd_data_reg;
    assign ts_done     = ts_done_reg;
    assign cur_ts      = cur_ts_reg;
    assign all_done    = all_done_reg;
    assign err         = err_reg;
endmodule
